bsg_axil_mux_rr: RTL and testbench
==================================

Name: bsg_axil_mux_rr

Overview:
Parametrised N-to-1 AXI4-Lite interconnect mux that merges num_s_p AXI-Lite managers onto one subordinate port. It has independent write and read arbiters, so a write from one manager and a read from another proceed concurrently. Each arbiter is round-robin and holds its grant until that channel's response handshake completes. It sits between BP/host AXI-Lite sources and the shared shell register or DRAM-bridge port, and pipelined managers are handled safely.

Parameters:
addr_width_p, (required), AXI-Lite address width
data_width_p, (required), AXI-Lite data width; multiple of 8
num_s_p, 2, number of manager-side (s) ports; >=2
lg_num_s_lp, `BSG_SAFE_CLOG2(num_s_p), grant index width (localparam)

Ports:
clk_i  in  1  single clock
reset_i  in  1  synchronous, active-high reset
s_axi_{awaddr,awprot,awvalid}_i  in  num_s_p*{addr_width_p,3,1}  packed AW per manager, index i at slice i
s_axi_awready_o  out  num_s_p  AW ready per manager
s_axi_{wdata,wstrb,wvalid}_i  in  num_s_p*{data_width_p,data_width_p/8,1}  packed W per manager
s_axi_wready_o  out  num_s_p  W ready per manager
s_axi_{bresp,bvalid}_o  out  num_s_p*{2,1}  B per manager
s_axi_bready_i  in  num_s_p  B ready per manager
s_axi_{araddr,arprot,arvalid}_i  in  num_s_p*{addr_width_p,3,1}  packed AR per manager
s_axi_arready_o  out  num_s_p  AR ready per manager
s_axi_{rdata,rresp,rvalid}_o  out  num_s_p*{data_width_p,2,1}  R per manager
s_axi_rready_i  in  num_s_p  R ready per manager
m_axi_aw*/w*/ar*_o, m_axi_bready_o, m_axi_rready_o  out  as per AXI-Lite  subordinate-side request channels
m_axi_aw/w/arready_i, m_axi_b*/r*_i  in  as per AXI-Lite  subordinate-side ready/response

Behaviour:
- Two independent FSMs (write, read), states e_idle, e_busy; reset -> e_idle, rr pointers -> 0, all done flags -> 0.
- Reset outputs: all *valid_o, *ready_o = 0. Data/resp outputs are don't-care but driven by the mux (no X).
- Write arbitration, e_idle: requesters = s_axi_awvalid_i. The round-robin winner is registered into wgrant_r, and the FSM moves to e_busy next cycle. An idle cycle with no request keeps e_idle.
- Round-robin: after a grant to i, priority order is i+1..num_s_p-1,0..i. After reset, port 0 has highest priority.
- Write e_busy:
  - m_axi_awvalid_o = awvalid[g] & ~aw_done_r; awready_o[g] = m_axi_awready_i & ~aw_done_r.
  - W is handled likewise with w_done_r.
  - AW and W are accepted independently, in either order or the same cycle. Each done flag sets on its handshake and blocks a second beat from the same manager.
  - B: bvalid_o[g] = m_axi_bvalid_i; m_axi_bready_o = bready[g]. On the B handshake: clear done flags, advance pointer, go to e_idle.
- Read e_busy:
  - AR is forwarded with an ar_done_r guard.
  - R: rvalid_o[g] = m_axi_rvalid_i; m_axi_rready_o = rready[g].
  - On the R handshake: clear, advance, go to e_idle.
- Ungranted managers always see ready = 0 and valid = 0. bresp/rdata/rresp are broadcast to all ports.
- Latency: one cycle from request valid to the m_* valid. Minimum one e_idle cycle between transactions on a channel, so peak throughput is one transaction per 3 cycles with a zero-wait subordinate.
- Read and write FSMs may grant the same or different managers simultaneously. No cross-channel ordering is enforced.
- A response arriving while m_* ready is low holds until accepted. The grant never changes while in e_busy.
- reset_i mid-transaction: return immediately to the reset state. Any in-flight subordinate response is dropped, which is the system's responsibility.
- A manager dropping valid before handshake is an AXI violation. The grant is still held until the response.

Decomposition:
- Package bsg_axil_mux_pkg:
  - state enum (e_idle, e_busy)
  - AXI-Lite resp constants (okay = 2'b00, slverr = 2'b10)
- Sub-module: bsg_axil_mux_rr_chan_arb, the round-robin arbiter plus grant register.
  - Instantiated twice: write and read.
  - Inputs: req vector and release pulse. Output: one-hot grant plus index.
  - Builds on bsg_arb_round_robin.

Test Plan:
- num_s_p=3, s1 single write addr 0x10 data 0xA5A5 with AW and W same cycle -> one m AW/W beat one cycle later, B okay to s1 only, s0/s2 see no valid/ready.
- s0 and s2 write simultaneously, repeated 4 times -> grant order 0,2,0,2. B routed to the matching manager each time; no AW duplication.
- s0 W presented 3 cycles before AW, subordinate awready delayed 2 cycles -> exactly one W and one AW beat, B delivered once.
- s0 write and s1 read issued same cycle -> both forwarded concurrently. R data 0xDEADBEEF reaches only s1, B reaches only s0.
- Response backpressure: rready low for 5 cycles -> rvalid_o held, grant unchanged, new s0 AR not forwarded until after the R handshake.
- reset_i asserted in e_busy mid-write -> next cycle all valids/readies 0, and a fresh s1 request is granted first.

Source files
------------

// File: rtl/bsg_axil_mux_pkg.sv
// bsg_axil_mux_pkg: shared state encoding and AXI-Lite response codes for the AXI-Lite mux
package bsg_axil_mux_pkg;
  typedef enum logic {e_idle, e_busy} state_e;
  localparam logic [1:0] axil_resp_okay = 2'b00;
  localparam logic [1:0] axil_resp_slverr = 2'b10;
endpackage

// File: rtl/bsg_axil_mux_rr_chan_arb.sv
// bsg_axil_mux_rr_chan_arb: round-robin arbiter with a grant register held until the release pulse
module bsg_axil_mux_rr_chan_arb
  import bsg_axil_mux_pkg::*;
#(
  parameter int num_s_p = 2,
  localparam int lg_num_s_lp = (num_s_p > 1) ? $clog2(num_s_p) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [num_s_p-1:0]     req_i,
  input  logic                   release_i,
  output logic                   busy_o,
  output logic [num_s_p-1:0]     grant_oh_o,
  output logic [lg_num_s_lp-1:0] grant_idx_o
);
  localparam logic [num_s_p-1:0] one_lp = num_s_p'(1);
  state_e state_r;
  logic [lg_num_s_lp-1:0] ptr_r, grant_r, win;
  logic found;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = 0; k < num_s_p; k++) begin
      if (!found && req_i[(int'(ptr_r) + k) % num_s_p]) begin
        found = 1'b1;
        win = lg_num_s_lp'((int'(ptr_r) + k) % num_s_p);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      ptr_r <= '0;
      grant_r <= '0;
    end else if (state_r == e_idle) begin
      if (found) begin
        grant_r <= win;
        state_r <= e_busy;
      end
    end else if (release_i) begin
      state_r <= e_idle;
      ptr_r <= (grant_r == lg_num_s_lp'(num_s_p - 1)) ? '0 : grant_r + 1'b1;
    end
  end
  assign busy_o = (state_r == e_busy);
  assign grant_oh_o = busy_o ? (one_lp << grant_r) : '0;
  assign grant_idx_o = grant_r;
endmodule

// File: rtl/bsg_axil_mux_rr.sv
// bsg_axil_mux_rr: N-to-1 AXI-Lite mux with independent round-robin write and read arbiters
module bsg_axil_mux_rr
  import bsg_axil_mux_pkg::*;
#(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int num_s_p = 2,
  localparam int lg_num_s_lp = (num_s_p > 1) ? $clog2(num_s_p) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_s_p*addr_width_p-1:0]     s_axi_awaddr_i,
  input  logic [num_s_p*3-1:0]                s_axi_awprot_i,
  input  logic [num_s_p-1:0]                  s_axi_awvalid_i,
  output logic [num_s_p-1:0]                  s_axi_awready_o,
  input  logic [num_s_p*data_width_p-1:0]     s_axi_wdata_i,
  input  logic [num_s_p*data_width_p/8-1:0]   s_axi_wstrb_i,
  input  logic [num_s_p-1:0]                  s_axi_wvalid_i,
  output logic [num_s_p-1:0]                  s_axi_wready_o,
  output logic [num_s_p*2-1:0]                s_axi_bresp_o,
  output logic [num_s_p-1:0]                  s_axi_bvalid_o,
  input  logic [num_s_p-1:0]                  s_axi_bready_i,
  input  logic [num_s_p*addr_width_p-1:0]     s_axi_araddr_i,
  input  logic [num_s_p*3-1:0]                s_axi_arprot_i,
  input  logic [num_s_p-1:0]                  s_axi_arvalid_i,
  output logic [num_s_p-1:0]                  s_axi_arready_o,
  output logic [num_s_p*data_width_p-1:0]     s_axi_rdata_o,
  output logic [num_s_p*2-1:0]                s_axi_rresp_o,
  output logic [num_s_p-1:0]                  s_axi_rvalid_o,
  input  logic [num_s_p-1:0]                  s_axi_rready_i,
  output logic [addr_width_p-1:0]             m_axi_awaddr_o,
  output logic [2:0]                          m_axi_awprot_o,
  output logic                                m_axi_awvalid_o,
  input  logic                                m_axi_awready_i,
  output logic [data_width_p-1:0]             m_axi_wdata_o,
  output logic [data_width_p/8-1:0]           m_axi_wstrb_o,
  output logic                                m_axi_wvalid_o,
  input  logic                                m_axi_wready_i,
  input  logic [1:0]                          m_axi_bresp_i,
  input  logic                                m_axi_bvalid_i,
  output logic                                m_axi_bready_o,
  output logic [addr_width_p-1:0]             m_axi_araddr_o,
  output logic [2:0]                          m_axi_arprot_o,
  output logic                                m_axi_arvalid_o,
  input  logic                                m_axi_arready_i,
  input  logic [data_width_p-1:0]             m_axi_rdata_i,
  input  logic [1:0]                          m_axi_rresp_i,
  input  logic                                m_axi_rvalid_i,
  output logic                                m_axi_rready_o
);
  localparam int sw_lp = data_width_p / 8;
  logic wbusy, rbusy, b_fire, r_fire;
  logic aw_done_r, w_done_r, ar_done_r;
  logic [num_s_p-1:0] wg_oh, rg_oh;
  logic [lg_num_s_lp-1:0] wg, rg;
  bsg_axil_mux_rr_chan_arb #(.num_s_p(num_s_p)) warb (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(s_axi_awvalid_i), .release_i(b_fire),
    .busy_o(wbusy), .grant_oh_o(wg_oh), .grant_idx_o(wg)
  );
  bsg_axil_mux_rr_chan_arb #(.num_s_p(num_s_p)) rarb (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(s_axi_arvalid_i), .release_i(r_fire),
    .busy_o(rbusy), .grant_oh_o(rg_oh), .grant_idx_o(rg)
  );
  assign m_axi_awaddr_o = s_axi_awaddr_i[wg*addr_width_p +: addr_width_p];
  assign m_axi_awprot_o = s_axi_awprot_i[wg*3 +: 3];
  assign m_axi_awvalid_o = wbusy & s_axi_awvalid_i[wg] & ~aw_done_r;
  assign s_axi_awready_o = wg_oh & {num_s_p{m_axi_awready_i & ~aw_done_r}};
  assign m_axi_wdata_o = s_axi_wdata_i[wg*data_width_p +: data_width_p];
  assign m_axi_wstrb_o = s_axi_wstrb_i[wg*sw_lp +: sw_lp];
  assign m_axi_wvalid_o = wbusy & s_axi_wvalid_i[wg] & ~w_done_r;
  assign s_axi_wready_o = wg_oh & {num_s_p{m_axi_wready_i & ~w_done_r}};
  assign s_axi_bresp_o = {num_s_p{m_axi_bresp_i}};
  assign s_axi_bvalid_o = wg_oh & {num_s_p{m_axi_bvalid_i}};
  assign m_axi_bready_o = wbusy & s_axi_bready_i[wg];
  assign b_fire = m_axi_bvalid_i & m_axi_bready_o;
  assign m_axi_araddr_o = s_axi_araddr_i[rg*addr_width_p +: addr_width_p];
  assign m_axi_arprot_o = s_axi_arprot_i[rg*3 +: 3];
  assign m_axi_arvalid_o = rbusy & s_axi_arvalid_i[rg] & ~ar_done_r;
  assign s_axi_arready_o = rg_oh & {num_s_p{m_axi_arready_i & ~ar_done_r}};
  assign s_axi_rdata_o = {num_s_p{m_axi_rdata_i}};
  assign s_axi_rresp_o = {num_s_p{m_axi_rresp_i}};
  assign s_axi_rvalid_o = rg_oh & {num_s_p{m_axi_rvalid_i}};
  assign m_axi_rready_o = rbusy & s_axi_rready_i[rg];
  assign r_fire = m_axi_rvalid_i & m_axi_rready_o;
  always_ff @(posedge clk_i) begin
    if (reset_i | b_fire) begin
      aw_done_r <= 1'b0;
      w_done_r <= 1'b0;
    end else begin
      aw_done_r <= aw_done_r | (m_axi_awvalid_o & m_axi_awready_i);
      w_done_r <= w_done_r | (m_axi_wvalid_o & m_axi_wready_i);
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i | r_fire) ar_done_r <= 1'b0;
    else ar_done_r <= ar_done_r | (m_axi_arvalid_o & m_axi_arready_i);
  end
endmodule

// File: tb/tb_bsg_axil_mux_rr.sv
// tb_bsg_axil_mux_rr: directed self-checking bench for the AXI-Lite round-robin mux
module tb_bsg_axil_mux_rr;
  import bsg_axil_mux_pkg::*;
  localparam int n = 3;
  localparam int aw = 16;
  localparam int dw = 32;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic [n*aw-1:0] s_awaddr, s_araddr;
  logic [n*3-1:0] s_awprot, s_arprot;
  logic [n-1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [n-1:0] s_arvalid, s_arready, s_rvalid, s_rready;
  logic [n*dw-1:0] s_wdata, s_rdata;
  logic [n*dw/8-1:0] s_wstrb;
  logic [n*2-1:0] s_bresp, s_rresp;
  logic [aw-1:0] m_awaddr, m_araddr;
  logic [2:0] m_awprot, m_arprot;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic [dw-1:0] m_wdata, m_rdata;
  logic [dw/8-1:0] m_wstrb;
  logic [1:0] m_bresp, m_rresp;
  int pass_cnt = 0;
  int total_cnt = 0;
  int aw_beats = 0;
  int w_beats = 0;
  int b_beats = 0;
  bsg_axil_mux_rr #(.addr_width_p(aw), .data_width_p(dw), .num_s_p(n)) dut (
    .clk_i(clk), .reset_i(reset),
    .s_axi_awaddr_i(s_awaddr), .s_axi_awprot_i(s_awprot), .s_axi_awvalid_i(s_awvalid), .s_axi_awready_o(s_awready),
    .s_axi_wdata_i(s_wdata), .s_axi_wstrb_i(s_wstrb), .s_axi_wvalid_i(s_wvalid), .s_axi_wready_o(s_wready),
    .s_axi_bresp_o(s_bresp), .s_axi_bvalid_o(s_bvalid), .s_axi_bready_i(s_bready),
    .s_axi_araddr_i(s_araddr), .s_axi_arprot_i(s_arprot), .s_axi_arvalid_i(s_arvalid), .s_axi_arready_o(s_arready),
    .s_axi_rdata_o(s_rdata), .s_axi_rresp_o(s_rresp), .s_axi_rvalid_o(s_rvalid), .s_axi_rready_i(s_rready),
    .m_axi_awaddr_o(m_awaddr), .m_axi_awprot_o(m_awprot), .m_axi_awvalid_o(m_awvalid), .m_axi_awready_i(m_awready),
    .m_axi_wdata_o(m_wdata), .m_axi_wstrb_o(m_wstrb), .m_axi_wvalid_o(m_wvalid), .m_axi_wready_i(m_wready),
    .m_axi_bresp_i(m_bresp), .m_axi_bvalid_i(m_bvalid), .m_axi_bready_o(m_bready),
    .m_axi_araddr_o(m_araddr), .m_axi_arprot_o(m_arprot), .m_axi_arvalid_o(m_arvalid), .m_axi_arready_i(m_arready),
    .m_axi_rdata_i(m_rdata), .m_axi_rresp_i(m_rresp), .m_axi_rvalid_i(m_rvalid), .m_axi_rready_o(m_rready)
  );
  always @(posedge clk) begin
    if (m_awvalid && m_awready) aw_beats <= aw_beats + 1;
    if (m_wvalid && m_wready) w_beats <= w_beats + 1;
    if (m_bvalid && m_bready) b_beats <= b_beats + 1;
  end
  task automatic set_aw(input int i, input logic [aw-1:0] a, input logic v);
    s_awaddr[i*aw +: aw] = a;
    s_awvalid[i] = v;
  endtask
  task automatic set_w(input int i, input logic [dw-1:0] d, input logic v);
    s_wdata[i*dw +: dw] = d;
    s_wstrb[i*4 +: 4] = 4'hF;
    s_wvalid[i] = v;
  endtask
  task automatic set_ar(input int i, input logic [aw-1:0] a, input logic v);
    s_araddr[i*aw +: aw] = a;
    s_arvalid[i] = v;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s_awaddr = '0; s_awprot = '0; s_awvalid = '0; s_wdata = '0; s_wstrb = '0; s_wvalid = '0; s_bready = '0;
    s_araddr = '0; s_arprot = '0; s_arvalid = '0; s_rready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = axil_resp_okay; m_bvalid = 1'b0;
    m_arready = 1'b0; m_rdata = '0; m_rresp = axil_resp_okay; m_rvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    #1;
    total_cnt++;
    if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0)
      $display("FAIL reset_m_ctrl got %b want 00000", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready});
    else pass_cnt++;
    total_cnt++;
    if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid} !== 15'b0)
      $display("FAIL reset_s_ctrl got %b want 0", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid});
    else pass_cnt++;
    total_cnt++;
    if ({m_awaddr, m_wdata, m_araddr, s_rdata} !== '0)
      $display("FAIL reset_data got %h want 0", {m_awaddr, m_wdata, m_araddr});
    else pass_cnt++;
  endtask
  task automatic test_single_write();
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1; s_bready = '1;
    set_aw(1, 16'h0010, 1'b1);
    set_w(1, 32'h0000A5A5, 1'b1);
    @(negedge clk); #1;
    total_cnt++;
    if ({m_awvalid, m_awaddr, m_wvalid, m_wdata} !== {1'b1, 16'h0010, 1'b1, 32'h0000A5A5})
      $display("FAIL single_fwd got %b/%h/%b/%h want 1/0010/1/0000a5a5", m_awvalid, m_awaddr, m_wvalid, m_wdata);
    else pass_cnt++;
    total_cnt++;
    if ({s_awready, s_wready, s_bvalid} !== 9'b010_010_000)
      $display("FAIL single_ready got %b want 010010000", {s_awready, s_wready, s_bvalid});
    else pass_cnt++;
    @(negedge clk);
    set_aw(1, '0, 1'b0);
    set_w(1, '0, 1'b0);
    m_bvalid = 1'b1;
    #1;
    total_cnt++;
    if ({s_bvalid, s_bresp[2 +: 2], m_awvalid, m_wvalid} !== {3'b010, axil_resp_okay, 1'b0, 1'b0})
      $display("FAIL single_b got %b want 010000", {s_bvalid, s_bresp[2 +: 2], m_awvalid, m_wvalid});
    else pass_cnt++;
    @(negedge clk);
    m_bvalid = 1'b0;
    #1;
    total_cnt++;
    if ({s_bvalid, s_awready, m_bready} !== 7'b0)
      $display("FAIL single_idle got %b want 0", {s_bvalid, s_awready, m_bready});
    else pass_cnt++;
  endtask
  task automatic test_rr_order();
    logic [aw-1:0] ea;
    logic [n-1:0] eoh;
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1; s_bready = '1;
    set_aw(0, 16'h0100, 1'b1); set_w(0, 32'h100, 1'b1);
    set_aw(2, 16'h0200, 1'b1); set_w(2, 32'h200, 1'b1);
    for (int it = 0; it < 4; it++) begin
      ea = (it % 2 == 1) ? 16'h0200 : 16'h0100;
      eoh = (it % 2 == 1) ? 3'b100 : 3'b001;
      @(negedge clk); #1;
      total_cnt++;
      if ({m_awaddr, s_awready} !== {ea, eoh})
        $display("FAIL rr_grant it%0d got %h/%b want %h/%b", it, m_awaddr, s_awready, ea, eoh);
      else pass_cnt++;
      @(negedge clk);
      m_bvalid = 1'b1;
      #1;
      total_cnt++;
      if ({m_awvalid, m_wvalid, s_bvalid} !== {2'b00, eoh})
        $display("FAIL rr_b it%0d got %b want 00%b", it, {m_awvalid, m_wvalid, s_bvalid}, eoh);
      else pass_cnt++;
      @(negedge clk);
      m_bvalid = 1'b0;
    end
  endtask
  task automatic test_w_before_aw();
    int a0, w0, b0;
    do_reset();
    a0 = aw_beats; w0 = w_beats; b0 = b_beats;
    m_awready = 1'b0; m_wready = 1'b1; s_bready = '1;
    set_w(0, 32'h1111, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      total_cnt++;
      if ({s_wready, m_wvalid} !== 4'b0)
        $display("FAIL early_w c%0d got %b want 0000", k, {s_wready, m_wvalid});
      else pass_cnt++;
    end
    set_aw(0, 16'h0040, 1'b1);
    @(negedge clk); #1;
    total_cnt++;
    if ({m_awvalid, m_wvalid, s_awready, s_wready} !== 8'b11_000_001)
      $display("FAIL wfirst_fwd got %b want 11000001", {m_awvalid, m_wvalid, s_awready, s_wready});
    else pass_cnt++;
    @(negedge clk);
    set_w(0, '0, 1'b0);
    #1;
    total_cnt++;
    if ({m_awvalid, m_wvalid} !== 2'b10)
      $display("FAIL wfirst_hold got %b want 10", {m_awvalid, m_wvalid});
    else pass_cnt++;
    @(negedge clk);
    m_awready = 1'b1;
    @(negedge clk);
    set_aw(0, '0, 1'b0);
    m_bvalid = 1'b1;
    #1;
    total_cnt++;
    if ({s_bvalid, m_awvalid} !== 4'b0010)
      $display("FAIL wfirst_b got %b want 0010", {s_bvalid, m_awvalid});
    else pass_cnt++;
    @(negedge clk);
    m_bvalid = 1'b0;
    @(negedge clk); #1;
    total_cnt++;
    if ({aw_beats - a0, w_beats - w0, b_beats - b0} !== {32'd1, 32'd1, 32'd1})
      $display("FAIL wfirst_beats got aw%0d w%0d b%0d want 1 1 1", aw_beats - a0, w_beats - w0, b_beats - b0);
    else pass_cnt++;
  endtask
  task automatic test_concurrent();
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1; s_bready = '1; s_rready = '1;
    set_aw(0, 16'h0020, 1'b1); set_w(0, 32'h2222, 1'b1);
    set_ar(1, 16'h0030, 1'b1);
    @(negedge clk); #1;
    total_cnt++;
    if ({m_awvalid, m_awaddr, m_arvalid, m_araddr, s_awready, s_arready} !== {1'b1, 16'h0020, 1'b1, 16'h0030, 3'b001, 3'b010})
      $display("FAIL conc_fwd got %b/%h/%b/%h/%b/%b", m_awvalid, m_awaddr, m_arvalid, m_araddr, s_awready, s_arready);
    else pass_cnt++;
    @(negedge clk);
    set_aw(0, '0, 1'b0); set_w(0, '0, 1'b0); set_ar(1, '0, 1'b0);
    m_bvalid = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF;
    #1;
    total_cnt++;
    if ({s_bvalid, s_rvalid, s_rdata[dw +: dw]} !== {3'b001, 3'b010, 32'hDEADBEEF})
      $display("FAIL conc_resp got %b/%b/%h want 001/010/deadbeef", s_bvalid, s_rvalid, s_rdata[dw +: dw]);
    else pass_cnt++;
    @(negedge clk);
    m_bvalid = 1'b0; m_rvalid = 1'b0;
    #1;
    total_cnt++;
    if ({s_bvalid, s_rvalid, m_bready, m_rready} !== 8'b0)
      $display("FAIL conc_done got %b want 0", {s_bvalid, s_rvalid, m_bready, m_rready});
    else pass_cnt++;
  endtask
  task automatic test_backpressure();
    do_reset();
    m_arready = 1'b1;
    set_ar(1, 16'h0050, 1'b1);
    @(negedge clk); #1;
    total_cnt++;
    if ({m_arvalid, m_araddr} !== {1'b1, 16'h0050})
      $display("FAIL bp_ar got %b/%h want 1/0050", m_arvalid, m_araddr);
    else pass_cnt++;
    @(negedge clk);
    set_ar(1, '0, 1'b0);
    set_ar(0, 16'h0060, 1'b1);
    m_rvalid = 1'b1; m_rdata = 32'h12345678;
    for (int k = 0; k < 5; k++) begin
      #1;
      total_cnt++;
      if ({s_rvalid, m_rready, m_arvalid, s_arready, s_rdata[dw +: dw]} !== {3'b010, 2'b00, 3'b000, 32'h12345678})
        $display("FAIL bp_hold c%0d got %b/%h want 01000000/12345678", k, {s_rvalid, m_rready, m_arvalid, s_arready}, s_rdata[dw +: dw]);
      else pass_cnt++;
      if (k < 4) @(negedge clk);
    end
    s_rready[1] = 1'b1;
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    total_cnt++;
    if ({m_arvalid, s_rvalid} !== 4'b0)
      $display("FAIL bp_idle got %b want 0000", {m_arvalid, s_rvalid});
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if ({m_arvalid, m_araddr, s_arready} !== {1'b1, 16'h0060, 3'b001})
      $display("FAIL bp_next got %b/%h/%b want 1/0060/001", m_arvalid, m_araddr, s_arready);
    else pass_cnt++;
  endtask
  task automatic test_reset_midway();
    do_reset();
    m_awready = 1'b0; m_wready = 1'b0; s_bready = '1;
    set_aw(0, 16'h0080, 1'b1); set_w(0, 32'h8080, 1'b1);
    @(negedge clk); #1;
    total_cnt++;
    if (m_awvalid !== 1'b1)
      $display("FAIL mid_busy got %b want 1", m_awvalid);
    else pass_cnt++;
    reset = 1'b1;
    set_aw(0, '0, 1'b0); set_w(0, '0, 1'b0);
    set_aw(1, 16'h0070, 1'b1); set_w(1, 32'h7070, 1'b1);
    m_awready = 1'b1; m_wready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid} !== 12'b0)
      $display("FAIL mid_reset got %b want 0", {m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid});
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if ({m_awvalid, m_awaddr, s_awready, s_wready} !== {1'b1, 16'h0070, 3'b010, 3'b010})
      $display("FAIL mid_fresh got %b/%h/%b/%b want 1/0070/010/010", m_awvalid, m_awaddr, s_awready, s_wready);
    else pass_cnt++;
  endtask
  initial begin
    reset = 1'b1;
    test_reset();
    test_single_write();
    test_rr_order();
    test_w_before_aw();
    test_concurrent();
    test_backpressure();
    test_reset_midway();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
